// File: rtl/minterm_pkg.sv
// Shared constants and state type for the minterm scanner.
package minterm_pkg;

  localparam int N_VARS_DEFAULT = 11;
  localparam int SCAN_LEN       = 1 << N_VARS_DEFAULT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/minterm_out_slot.sv
// One-entry valid/ready holding register for minterm indices.
module minterm_out_slot #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] index,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [W-1:0] m_index,
  output logic         free
);

  // Free when empty or when the held entry is being taken this cycle,
  // which allows back-to-back reloads without a bubble.
  assign free = !m_valid || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_index <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_index <= index;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/minterm_scanner.sv
// Walks every input vector of an N_VARS-input function and streams the true indices.
// Optional MINTERM_SCANNER_MAXTERM_EN adds a polarity input to report false indices instead.
module minterm_scanner
  import minterm_pkg::*;
#(
  parameter int N_VARS = N_VARS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef MINTERM_SCANNER_MAXTERM_EN
  input  logic              polarity,
`endif
  output logic              busy,
  output logic              done,
  output logic [N_VARS-1:0] dut_in,
  input  logic              dut_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_VARS-1:0] m_index,
  output logic [N_VARS:0]   m_count,
  output state_t            state_dbg
);

  localparam logic [N_VARS-1:0] LAST_IDX = '1;

  // Handshake: an index transfers on any rising edge where m_valid && m_ready;
  // while m_valid && !m_ready, m_index and m_valid are held unchanged.

  state_t            state, state_d;
  logic [N_VARS-1:0] idx;
  logic              hit, load, adv, clear, slot_free;

`ifdef MINTERM_SCANNER_MAXTERM_EN
  logic pol_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pol_q <= 1'b0;
    else if (clear) pol_q <= polarity;
  end

  assign hit = dut_out ^ pol_q;
`else
  assign hit = dut_out;
`endif

  always_comb begin
    state_d = state;
    load    = 1'b0;
    adv     = 1'b0;
    clear   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          clear   = 1'b1;
        end
      end
      SCAN: begin
        // A hit that cannot be stored stalls the scan on the same index.
        if (hit) begin
          if (slot_free) begin
            load = 1'b1;
            adv  = 1'b1;
          end
        end else begin
          adv = 1'b1;
        end
        if (adv && idx == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        if (slot_free) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      m_count <= '0;
    end else begin
      state <= state_d;
      if (clear)    idx <= '0;
      else if (adv) idx <= idx + N_VARS'(1);
      if (clear)     m_count <= '0;
      else if (load) m_count <= m_count + (N_VARS + 1)'(1);
    end
  end

  minterm_out_slot #(.W(N_VARS)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .index   (idx),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_index (m_index),
    .free    (slot_free)
  );

  assign dut_in    = idx;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
